// File: rtl/pipelined_addsub.sv
// Segmented-carry add/subtract pipeline: the carry ripples one SEG-bit segment per stage.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic [7:0]       i_tag,
`ifdef ADDSUB_SAT_EN
    input  logic             i_sat,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic [7:0]       o_tag,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic [7:0]       tag_q [STAGES];

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic [7:0]       tag_in [STAGES];
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic             c_d    [STAGES];
    logic [SEG:0]     seg;

`ifdef ADDSUB_SAT_EN
    logic sat_q  [STAGES];
    logic sat_in [STAGES];
`endif

    logic [WIDTH-1:0] sum_q;
    logic [7:0]       otag_q;
    logic             cout_q, ovf_q, zero_q, neg_q;

    logic [WIDTH-1:0] raw_sum, fin_sum;
    logic             fin_ovf, sat_last;

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic a_msb,
                                                  input logic sat_en,
                                                  input logic ovf);
        if (sat_en && ovf)
            return a_msb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        return raw;
    endfunction

    always_comb begin
        a_in[0]   = i_a;
        b_in[0]   = i_sub ? ~i_b : i_b;
        s_in[0]   = '0;
        c_in[0]   = i_sub;
        tag_in[0] = i_tag;
        v_in[0]   = i_valid;
`ifdef ADDSUB_SAT_EN
        sat_in[0] = i_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
            tag_in[k] = tag_q[k-1];
            v_in[k]   = v_q[k-1];
`ifdef ADDSUB_SAT_EN
            sat_in[k] = sat_q[k-1];
`endif
        end
        seg = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                  + (SEG+1)'(c_in[k]);
            s_d[k] = s_in[k];
            s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
            c_d[k] = seg[SEG];
        end
        // A stage may load when empty or when its occupant moves on; empty stages soak up bubbles.
        adv[LAST] = !v_q[LAST] || i_ready;
        for (int k = LAST - 1; k >= 0; k--)
            adv[k] = !v_q[k] || adv[k+1];
    end

`ifdef ADDSUB_SAT_EN
    assign sat_last = sat_in[LAST];
`else
    assign sat_last = 1'b0;
`endif

    assign raw_sum = s_d[LAST];
    assign fin_ovf = (a_in[LAST][MSB] == b_in[LAST][MSB]) && (raw_sum[MSB] != a_in[LAST][MSB]);
    assign fin_sum = saturate(raw_sum, a_in[LAST][MSB], sat_last, fin_ovf);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v_q    <= '0;
            sum_q  <= '0;
            otag_q <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (adv[k]) v_q[k] <= v_in[k];
            if (adv[LAST] && v_in[LAST]) begin
                sum_q  <= fin_sum;
                otag_q <= tag_in[LAST];
                cout_q <= c_d[LAST];
                ovf_q  <= fin_ovf;
                zero_q <= (fin_sum == '0);
                neg_q  <= fin_sum[MSB];
            end
        end
        // Intermediate segment state is don't-care while its valid bit is clear.
        for (int k = 0; k < LAST; k++) begin
            if (adv[k] && v_in[k]) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                tag_q[k] <= tag_in[k];
`ifdef ADDSUB_SAT_EN
                sat_q[k] <= sat_in[k];
`endif
            end
        end
    end

    assign o_ready = adv[0];
    assign o_valid = v_q[LAST];
    assign o_sum   = sum_q;
    assign o_tag   = otag_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;
    assign o_neg   = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 4-stage main instance plus 1- and 32-stage builds.
module tb_pipelined_addsub;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, vld, sub, sat, ir4, one;
    logic [31:0] a, b;
    logic [7:0]  tag;

    logic        ordy4, ov4, cout4, ovf4, zero4, neg4;
    logic [31:0] sum4;
    logic [7:0]  tag4;
    logic        ordy1, ov1, cout1, ovf1, zero1, neg1;
    logic [31:0] sum1;
    logic [7:0]  tag1;
    logic        ordy32, ov32, cout32, ovf32, zero32, neg32;
    logic [31:0] sum32;
    logic [7:0]  tag32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(ordy4),
        .i_a(a), .i_b(b), .i_sub(sub), .i_tag(tag),
`ifdef ADDSUB_SAT_EN
        .i_sat(sat),
`endif
        .o_valid(ov4), .i_ready(ir4), .o_sum(sum4), .o_tag(tag4),
        .o_cout(cout4), .o_ovf(ovf4), .o_zero(zero4), .o_neg(neg4));

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(ordy1),
        .i_a(a), .i_b(b), .i_sub(sub), .i_tag(tag),
`ifdef ADDSUB_SAT_EN
        .i_sat(sat),
`endif
        .o_valid(ov1), .i_ready(one), .o_sum(sum1), .o_tag(tag1),
        .o_cout(cout1), .o_ovf(ovf1), .o_zero(zero1), .o_neg(neg1));

    pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_valid(vld), .o_ready(ordy32),
        .i_a(a), .i_b(b), .i_sub(sub), .i_tag(tag),
`ifdef ADDSUB_SAT_EN
        .i_sat(sat),
`endif
        .o_valid(ov32), .i_ready(one), .o_sum(sum32), .o_tag(tag32),
        .o_cout(cout32), .o_ovf(ovf32), .o_zero(zero32), .o_neg(neg32));

    // Offers one operation, then waits until the 4-stage result should appear.
    // lat_ok is 1 only if it was accepted at once and o_valid rose exactly 4 cycles later.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic isat, input logic [7:0] itag, output logic lat_ok);
        @(negedge clk);
        a = ia; b = ib; sub = isub; sat = isat; tag = itag; vld = 1'b1;
        #1 lat_ok = ordy4;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld = 1'b0;
            if (ov4 !== 1'b0) lat_ok = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        vld = 1'b0;
        if (ov4 !== 1'b1) lat_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; vld = 1'b0; ir4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov4); end
        checks++; if (sum4 !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum4); end
        checks++; if (tag4 !== 8'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag4); end
        checks++; if ({cout4, ovf4, zero4, neg4} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {cout4, ovf4, zero4, neg4}); end
        checks++; if (ordy4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ordy4); end
    endtask

    task automatic test_add;
        logic lat;
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 8'h11, lat);
        checks++; if (lat !== 1'b1) begin errors++; $display("FAIL add_latency: got %b want 1", lat); end
        checks++; if (sum4 !== 32'h0001_0000) begin errors++; $display("FAIL add_sum: got %h want 00010000", sum4); end
        checks++; if (tag4 !== 8'h11) begin errors++; $display("FAIL add_tag: got %h want 11", tag4); end
        checks++; if ({cout4, ovf4, zero4, neg4} !== 4'b0000) begin
            errors++; $display("FAIL add_flags: got %b want 0000", {cout4, ovf4, zero4, neg4}); end
    endtask

    task automatic test_sub;
        logic lat;
        issue(32'd5, 32'd5, 1'b1, 1'b0, 8'h21, lat);
        checks++; if (lat !== 1'b1 || sum4 !== 32'h0 || tag4 !== 8'h21) begin
            errors++; $display("FAIL sub_eq: got lat=%b sum=%h tag=%h want 1 0 21", lat, sum4, tag4); end
        checks++; if ({cout4, ovf4, zero4, neg4} !== 4'b1010) begin
            errors++; $display("FAIL sub_eq_flags: got %b want 1010", {cout4, ovf4, zero4, neg4}); end
        issue(32'd3, 32'd5, 1'b1, 1'b0, 8'h22, lat);
        checks++; if (lat !== 1'b1 || sum4 !== 32'hFFFF_FFFE || tag4 !== 8'h22) begin
            errors++; $display("FAIL sub_neg: got lat=%b sum=%h tag=%h want 1 fffffffe 22", lat, sum4, tag4); end
        checks++; if ({cout4, ovf4, zero4, neg4} !== 4'b0001) begin
            errors++; $display("FAIL sub_neg_flags: got %b want 0001", {cout4, ovf4, zero4, neg4}); end
    endtask

    task automatic test_overflow;
        logic lat;
        logic [31:0] es;
        logic [3:0]  ef;
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 8'h31, lat);
        checks++; if (lat !== 1'b1 || sum4 !== 32'h8000_0000) begin
            errors++; $display("FAIL ovf_wrap: got lat=%b sum=%h want 1 80000000", lat, sum4); end
        checks++; if ({cout4, ovf4, zero4, neg4} !== 4'b0101) begin
            errors++; $display("FAIL ovf_wrap_flags: got %b want 0101", {cout4, ovf4, zero4, neg4}); end
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 8'h32, lat);
        if (SAT_BUILD && sat) begin es = 32'h7FFF_FFFF; ef = 4'b0100; end
        else begin es = 32'h8000_0000; ef = 4'b0101; end
        checks++; if (lat !== 1'b1 || sum4 !== es || {cout4, ovf4, zero4, neg4} !== ef) begin
            errors++; $display("FAIL ovf_pos_sat: got sum=%h flags=%b want %h %b", sum4, {cout4, ovf4, zero4, neg4}, es, ef); end
        issue(32'h8000_0000, 32'h1, 1'b1, 1'b1, 8'h33, lat);
        if (SAT_BUILD && sat) begin es = 32'h8000_0000; ef = 4'b1101; end
        else begin es = 32'h7FFF_FFFF; ef = 4'b1100; end
        checks++; if (lat !== 1'b1 || sum4 !== es || {cout4, ovf4, zero4, neg4} !== ef) begin
            errors++; $display("FAIL ovf_neg_sat: got sum=%h flags=%b want %h %b", sum4, {cout4, ovf4, zero4, neg4}, es, ef); end
    endtask

    task automatic test_back_to_back;
        int          next_issue = 0;
        int          next_exp = 0;
        int          extra = 0;
        logic [31:0] held_sum = '0;
        logic [7:0]  held_tag = '0;
        for (int c = 0; c < 60 && next_exp < 10; c++) begin
            @(negedge clk);
            ir4 = !(c >= 6 && c <= 9);
            if (next_issue < 10) begin
                vld = 1'b1; a = 32'h00FF_FFFF; b = 32'(next_issue);
                sub = 1'b0; sat = 1'b0; tag = 8'(next_issue);
            end else vld = 1'b0;
            #1;
            if (c == 6) begin
                checks++; if (ordy4 !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", ordy4); end
                checks++; if (ov4 !== 1'b1 || tag4 !== 8'd2) begin
                    errors++; $display("FAIL b2b_stall_head: got v=%b tag=%0d want 1 2", ov4, tag4); end
                held_sum = sum4; held_tag = tag4;
            end
            if (c >= 7 && c <= 9) begin
                checks++; if (ov4 !== 1'b1 || sum4 !== held_sum || tag4 !== held_tag) begin
                    errors++; $display("FAIL b2b_hold: got v=%b sum=%h tag=%h want 1 %h %h", ov4, sum4, tag4, held_sum, held_tag); end
            end
            if (c == 10) begin
                checks++; if (ordy4 !== 1'b1) begin errors++; $display("FAIL b2b_resume_ready: got %b want 1", ordy4); end
            end
            if (ov4 === 1'b1 && ir4 === 1'b1) begin
                checks++; if (tag4 !== 8'(next_exp) || sum4 !== 32'h00FF_FFFF + 32'(next_exp)) begin
                    errors++; $display("FAIL b2b_result: got tag=%0d sum=%h want %0d %h", tag4, sum4, next_exp, 32'h00FF_FFFF + 32'(next_exp)); end
                next_exp++;
            end
            if (vld === 1'b1 && ordy4 === 1'b1) next_issue++;
            @(posedge clk);
        end
        checks++; if (next_exp != 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", next_exp); end
        vld = 1'b0; ir4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov4 !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate: got %0d extra results want 0", extra); end
    endtask

    task automatic test_reset_flush;
        int   leaked = 0;
        logic lat;
        ir4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld = 1'b1; a = 32'(i); b = 32'd1; sub = 1'b0; sat = 1'b0; tag = 8'hA0 + 8'(i);
            @(posedge clk);
        end
        @(negedge clk);
        vld = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ov4 !== 1'b0 || ordy4 !== 1'b1) begin
            errors++; $display("FAIL flush_state: got v=%b rdy=%b want 0 1", ov4, ordy4); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov4 !== 1'b0) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL flush_leak: got %0d results want 0", leaked); end
        issue(32'd40, 32'd2, 1'b0, 1'b0, 8'h55, lat);
        checks++; if (lat !== 1'b1 || sum4 !== 32'd42 || tag4 !== 8'h55) begin
            errors++; $display("FAIL flush_after: got lat=%b sum=%h tag=%h want 1 2a 55", lat, sum4, tag4); end
    endtask

    task automatic test_stage_variants;
        int lat1 = 0;
        int lat32 = 0;
        rst = 1'b1; vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vld = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; sub = 1'b0; sat = 1'b0; tag = 8'h77;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            vld = 1'b0;
            if (ov1 === 1'b1 && lat1 == 0) begin
                lat1 = cyc;
                checks++; if (sum1 !== 32'h0 || {cout1, zero1} !== 2'b11 || tag1 !== 8'h77) begin
                    errors++; $display("FAIL s1_result: got sum=%h cout=%b zero=%b tag=%h want 0 1 1 77", sum1, cout1, zero1, tag1); end
            end
            if (ov32 === 1'b1 && lat32 == 0) begin
                lat32 = cyc;
                checks++; if (sum32 !== 32'h0 || {cout32, zero32} !== 2'b11 || tag32 !== 8'h77) begin
                    errors++; $display("FAIL s32_result: got sum=%h cout=%b zero=%b tag=%h want 0 1 1 77", sum32, cout32, zero32, tag32); end
            end
            @(posedge clk);
        end
        checks++; if (lat1 != 1) begin errors++; $display("FAIL s1_latency: got %0d want 1", lat1); end
        checks++; if (lat32 != 32) begin errors++; $display("FAIL s32_latency: got %0d want 32", lat32); end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; sub = 1'b0; sat = 1'b0; ir4 = 1'b1; one = 1'b1;
        a = '0; b = '0; tag = '0;
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_back_to_back;
        test_reset_flush;
        test_stage_variants;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit for the RISC-V datapath.
- Splits a WIDTH-bit carry chain into STAGES registered segments, so the carry ripples one segment per cycle.
- Each result leaves with carry, signed-overflow, zero and negative flags.
- Elastic valid/ready handshake on both sides with per-stage bubble collapsing. Drop-in for long-latency arithmetic or for multi-cycle execute experiments.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit can accept an operation this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_sub  in  1  0: A+B, 1: A-B (A + ~B + 1).
- i_tag  in  8  opaque ID, returned unchanged with the result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result.
- o_tag  out  8  tag of the result.
- o_cout  out  1  carry out of MSB; for subtract, 1 means no borrow (A >= B unsigned).
- o_ovf  out  1  signed overflow.
- o_zero  out  1  o_sum == 0.
- o_neg  out  1  o_sum[WIDTH-1].

Behaviour:
- Reset, synchronous: all stage valid bits clear. o_valid=0; o_sum, o_tag, o_cout, o_ovf, o_zero, o_neg = 0. o_ready=1 in the first cycle after reset.
- Operand conditioning at acceptance: B' = i_sub ? ~i_b : i_b; carry-in = i_sub.
- Stage k (0..STAGES-1):
  - Adds segment k of A and B' with the carry registered by stage k-1 (stage 0 uses carry-in).
  - Registers its SEG-bit partial sum and carry.
  - Forwards the unconsumed upper segments of A and B', the lower partial sums, and the tag.
- Final stage registers the full result and computes flags:
  - o_ovf = (A[MSB] == B'[MSB]) && (o_sum[MSB] != A[MSB]).
  - o_zero and o_neg are computed from the final sum.
- Latency: exactly STAGES cycles from an accepted input (i_valid && o_ready) to o_valid, with no backpressure. STAGES=1 gives a single registered adder.
- Throughput: one operation per cycle while i_ready=1.
- Per-stage valid v[k]:
  - Stage k loads when it is empty or when stage k+1 loads / the output handshake fires.
  - o_ready = !v[0] || stage-0 advances.
  - Bubbles collapse: an empty middle stage accepts even if downstream is stalled.
- Output holding: while o_valid && !i_ready, all outputs stay stable. A full pipe then deasserts o_ready after the internal bubbles fill.
- Simultaneous accept at input and handshake at output in the same cycle is legal; occupancy is unchanged.
- Ordering: results emerge in strict input order; tags are never reordered or duplicated.
- i_valid with o_ready=0: the input is ignored, and the source must hold it.
- Reset asserted mid-operation: all in-flight operations are discarded, and nothing is emitted afterwards for them.
- Wrap-around is modulo 2^WIDTH; carry and overflow are reported only through the flags.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- When defined, port i_sat (in, 1) is added and travels with the operation.
  - If i_sat=1 and signed overflow occurs, o_sum clamps: to 0111..1 if A[MSB]=0, else to 1000..0.
  - o_ovf still reports 1; o_zero and o_neg are computed from the clamped value.
- When undefined: no i_sat port; the result always wraps.

Test Plan:
- Reset, then WIDTH=32, STAGES=4, i_ready=1: A=0x0000_FFFF, B=0x0000_0001, add -> after 4 cycles o_sum=0x0001_0000, o_cout=0, o_ovf=0, o_zero=0.
- Subtract A=5, B=5 -> o_sum=0, o_zero=1, o_cout=1. Subtract A=3, B=5 -> o_sum=0xFFFF_FFFE, o_neg=1, o_cout=0.
- Add A=0x7FFF_FFFF, B=1 -> o_sum=0x8000_0000, o_ovf=1. With ADDSUB_SAT_EN and i_sat=1 -> o_sum=0x7FFF_FFFF, o_ovf=1.
- Stream 10 back-to-back adds with tags 0..9. Drive i_ready low for cycles 6..9 -> outputs held stable, o_ready drops once all 4 stages are full, all 10 results emerge in tag order, none lost or duplicated.
- Issue 3 operations, assert i_reset for one cycle while they are in flight -> o_valid=0 next cycle and those 3 are never emitted; a new operation afterwards has latency 4.
- STAGES=1 and STAGES=32 builds: A=0xFFFF_FFFF, B=1 -> o_sum=0, o_cout=1, o_zero=1, latency 1 and 32 respectively.
